// File: rtl/button_event_decoder.sv
// button_event_decoder
// Turns a debounced push-button level into press, release, short-click,
// long-press and double-click pulses. All pulse outputs are registered and
// one clock wide. A single saturating 24-bit counter measures either the
// hold time of a press or the release gap between two presses.
//
// Build option: define BUTTON_DOUBLE_CLICK_EN to enable double-click
// detection (WAIT_GAP / SECOND_PRESSED states). Without it, every release
// of a short press immediately reports a short click and o_Double_Click is
// held at 0.
module button_event_decoder #(
    parameter int unsigned c_LONG_PRESS_CYCLES = 32'd12500000,
    parameter int unsigned c_DOUBLE_GAP_CYCLES = 32'd7500000
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Short_Click,
    output logic o_Long_Press,
    output logic o_Double_Click,
    output logic o_Busy
);

    localparam logic [23:0] c_LONG_CNT = c_LONG_PRESS_CYCLES[23:0];
`ifdef BUTTON_DOUBLE_CLICK_EN
    localparam logic [23:0] c_GAP_CNT  = c_DOUBLE_GAP_CYCLES[23:0];
`endif

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_PRESSED        = 3'd1,
        ST_HELD           = 3'd2
`ifdef BUTTON_DOUBLE_CLICK_EN
        ,
        ST_WAIT_GAP       = 3'd3,
        ST_SECOND_PRESSED = 3'd4
`endif
    } state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [23:0] sat_inc(input logic [23:0] v);
        if (v == 24'hFF_FFFF) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 24'd1;
        end
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [23:0] count_r;
    logic [23:0] count_s;
    logic [23:0] count_inc_s;
    logic        r_Switch_d;
    logic        rise_s;
    logic        fall_s;
    logic        press_s;
    logic        release_s;
    logic        short_s;
    logic        long_s;
`ifdef BUTTON_DOUBLE_CLICK_EN
    logic        double_s;
`endif

    assign rise_s      = i_Switch & ~r_Switch_d;
    assign fall_s      = ~i_Switch & r_Switch_d;
    assign count_inc_s = sat_inc(count_r);

    // Delayed switch copy for edge detection; resets high so a button held
    // through reset release is not seen as a new press.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Switch_d <= 1'b1;
        end else begin
            r_Switch_d <= i_Switch;
        end
    end

    // Next-state, counter and pulse decode for the button FSM.
    always_comb begin
        state_s   = state_r;
        count_s   = count_r;
        press_s   = 1'b0;
        release_s = 1'b0;
        short_s   = 1'b0;
        long_s    = 1'b0;
`ifdef BUTTON_DOUBLE_CLICK_EN
        double_s  = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    press_s = 1'b1;
                    count_s = 24'd1;
                    state_s = ST_PRESSED;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRESSED: begin
                if (fall_s) begin
                    release_s = 1'b1;
`ifdef BUTTON_DOUBLE_CLICK_EN
                    count_s   = 24'd1;
                    state_s   = ST_WAIT_GAP;
`else
                    short_s   = 1'b1;
                    state_s   = ST_IDLE;
`endif
                end else if (count_inc_s >= c_LONG_CNT) begin
                    long_s  = 1'b1;
                    count_s = count_inc_s;
                    state_s = ST_HELD;
                end else begin
                    count_s = count_inc_s;
                end
            end
            ST_HELD: begin
                // Long press already reported; the release ends it silently.
                if (fall_s) begin
                    release_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_HELD;
                end
            end
`ifdef BUTTON_DOUBLE_CLICK_EN
            ST_WAIT_GAP: begin
                // A second press wins over gap expiry on the same edge.
                if (rise_s && (count_r <= c_GAP_CNT)) begin
                    press_s = 1'b1;
                    count_s = 24'd1;
                    state_s = ST_SECOND_PRESSED;
                end else if (count_inc_s >= c_GAP_CNT) begin
                    short_s = 1'b1;
                    count_s = count_inc_s;
                    state_s = ST_IDLE;
                end else begin
                    count_s = count_inc_s;
                end
            end
            ST_SECOND_PRESSED: begin
                if (fall_s) begin
                    release_s = 1'b1;
                    double_s  = 1'b1;
                    state_s   = ST_IDLE;
                end else if (count_inc_s >= c_LONG_CNT) begin
                    // Holding the second press turns the pair into a long press.
                    long_s  = 1'b1;
                    count_s = count_inc_s;
                    state_s = ST_HELD;
                end else begin
                    count_s = count_inc_s;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
                count_s = 24'd0;
            end
        endcase
    end

    // FSM state and shared counter registers.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_r <= ST_IDLE;
            count_r <= 24'd0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
        end
    end

    // Registered pulse and busy outputs, asserted on the causing edge.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Press       <= 1'b0;
            o_Release     <= 1'b0;
            o_Short_Click <= 1'b0;
            o_Long_Press  <= 1'b0;
            o_Busy        <= 1'b0;
        end else begin
            o_Press       <= press_s;
            o_Release     <= release_s;
            o_Short_Click <= short_s;
            o_Long_Press  <= long_s;
            o_Busy        <= (state_s != ST_IDLE);
        end
    end

`ifdef BUTTON_DOUBLE_CLICK_EN
    // Registered double-click pulse.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Double_Click <= 1'b0;
        end else begin
            o_Double_Click <= double_s;
        end
    end
`else
    assign o_Double_Click = 1'b0;
`endif

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 Parameter c_LONG_PRESS_CYCLES, default 12500000, sets the hold time that qualifies as a long press (500 ms at 25 MHz); legal range 2..2^24-1.
REQ-002 Parameter c_DOUBLE_GAP_CYCLES, default 7500000, sets the maximum release-to-second-press gap for a double click (300 ms at 25 MHz); legal range 2..2^24-1.
REQ-003 i_Clk  input  1  single system clock; all logic SHALL be on the rising edge.
REQ-004 i_Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_Switch  input  1  debounced switch level, synchronous to i_Clk, high = pressed.
REQ-006 o_Press  output  1  one-cycle pulse on each press.
REQ-007 o_Release  output  1  one-cycle pulse on each release.
REQ-008 o_Short_Click  output  1  one-cycle pulse on a completed single short click.
REQ-009 o_Long_Press  output  1  one-cycle pulse when the hold time reaches c_LONG_PRESS_CYCLES.
REQ-010 o_Double_Click  output  1  one-cycle pulse on a completed double click.
REQ-011 o_Busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 Edge detection SHALL use a registered copy r_Switch_d: rise = i_Switch & ~r_Switch_d; fall = ~i_Switch & r_Switch_d.
REQ-013 All pulse outputs SHALL be registered, one cycle wide, and asserted on the clock edge that samples the causing condition.
REQ-014 The FSM states SHALL be IDLE, PRESSED, HELD, WAIT_GAP and SECOND_PRESSED, with one shared 24-bit counter.
REQ-015 In IDLE, on a rise: assert o_Press, clear the counter to 1, and go to PRESSED; a fall in IDLE SHALL be ignored.
REQ-016 In PRESSED, while high: increment the counter; when the count reaches c_LONG_PRESS_CYCLES, assert o_Long_Press and go to HELD.
REQ-017 In PRESSED, on a fall: assert o_Release, clear the counter to 1, and go to WAIT_GAP (see REQ-025 for the no-macro case).
REQ-018 In HELD, on a fall: assert o_Release and go to IDLE; no click output SHALL be produced.
REQ-019 In WAIT_GAP, on a rise with count <= c_DOUBLE_GAP_CYCLES: assert o_Press, clear the counter to 1, and go to SECOND_PRESSED.
REQ-020 In WAIT_GAP with no rise: increment the counter; when the count reaches c_DOUBLE_GAP_CYCLES, assert o_Short_Click and go to IDLE.
REQ-021 In SECOND_PRESSED, on a fall before the long threshold: assert o_Release and o_Double_Click on the same edge and go to IDLE.
REQ-022 In SECOND_PRESSED, on reaching c_LONG_PRESS_CYCLES: assert o_Long_Press and go to HELD; the pending first click SHALL be discarded.
REQ-023 The counter SHALL saturate and never wrap; no two of o_Short_Click, o_Long_Press and o_Double_Click SHALL assert on the same edge.

Reset
REQ-024 While i_Rst_n is low: FSM = IDLE, counter = 0, all outputs = 0, and r_Switch_d = 1, so a switch held through reset release SHALL NOT produce o_Press; reset mid-sequence SHALL abandon the sequence with no pulse.

Configuration
REQ-025 Macro BUTTON_DOUBLE_CLICK_EN:
- Defined: behaviour is as in REQ-014..REQ-023.
- Undefined: WAIT_GAP and SECOND_PRESSED are removed; a fall in PRESSED asserts o_Release and o_Short_Click on the same edge and returns to IDLE; o_Double_Click is tied to 0.

Verification (c_LONG_PRESS_CYCLES=8, c_DOUBLE_GAP_CYCLES=5, macro defined unless stated)
REQ-026 High for 3 cycles, then low -> o_Press at edge 1; o_Release on the fall edge; o_Short_Click exactly 4 edges after o_Release; o_Busy low afterwards.
REQ-027 High for 10 cycles -> o_Long_Press on the 8th high edge; o_Release on the fall edge; no click pulse.
REQ-028 High 3, low 2, high 3, low -> two o_Press pulses, then o_Release and o_Double_Click together on the final fall; no o_Short_Click.
REQ-029 High 3, low 2, high 9 -> o_Long_Press on the 8th high edge of the second press; no o_Double_Click and no o_Short_Click.
REQ-030 i_Switch high across the deassertion of i_Rst_n -> no o_Press; the following fall is ignored; the next full press-release gives a normal short click.
REQ-031 Macro undefined: high 3, low -> o_Release and o_Short_Click on the same edge; o_Double_Click stays 0 throughout.
